// File: rtl/riscv_dm_pkg.sv
// Shared DMI definitions for the debug-module slice: bus widths, op
// encodings and the state type used by the DMI request arbiter.
package riscv_dm_pkg;

    localparam int unsigned DMI_ADDR_WIDTH = 7;
    localparam int unsigned DMI_DATA_WIDTH = 32;
    localparam int unsigned DMI_OP_WIDTH   = 2;

    // Request op encodings (requester -> DM)
    localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_READ  = 2'd1;
    localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_WRITE = 2'd2;

    // Response op encodings (DM -> requester)
    localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_SUCCESS = 2'd0;
    localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_FAILED  = 2'd2;
    localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_BUSY    = 2'd3;

    // Arbiter transaction phases; at most one DM transaction in flight
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_REPLY
    } dmi_arb_state_e;

    // Index following idx in a ring of n entries
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first requester found when
// scanning upward from ptr (wrapping) wins.
module rr_arbiter
    import riscv_dm_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [31:0]      cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from ptr upward and take the first active request
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid      = 1'b1;
                gnt_idx        = cand_idx;
                gnt[cand_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// DMI arbiter: shares one riscv_dm DMI port between NUM_REQ requesters,
// one transaction at a time, round-robin between contenders.
// Optional feature macro: DMI_ARB_TIMEOUT_EN adds a DM response watchdog
// (TIMEOUT_CYCLES) that fails the transaction and drains one late response.
module dmi_arbiter
    import riscv_dm_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic [NUM_REQ-1:0]                  r_req_valid_i,
    output logic [NUM_REQ-1:0]                  r_req_ready_o,
    input  logic [NUM_REQ*DMI_ADDR_WIDTH-1:0]   r_req_addr_i,
    input  logic [NUM_REQ*DMI_DATA_WIDTH-1:0]   r_req_data_i,
    input  logic [NUM_REQ*DMI_OP_WIDTH-1:0]     r_req_op_i,
    output logic [NUM_REQ-1:0]                  r_resp_valid_o,
    input  logic [NUM_REQ-1:0]                  r_resp_ready_i,
    output logic [DMI_DATA_WIDTH-1:0]           r_resp_data_o,
    output logic [DMI_OP_WIDTH-1:0]             r_resp_op_o,

    output logic                                dm_req_valid_o,
    input  logic                                dm_req_ready_i,
    output logic [DMI_ADDR_WIDTH-1:0]           dm_req_addr_o,
    output logic [DMI_DATA_WIDTH-1:0]           dm_req_data_o,
    output logic [DMI_OP_WIDTH-1:0]             dm_req_op_o,

    input  logic                                dm_resp_valid_i,
    output logic                                dm_resp_ready_o,
    input  logic [DMI_DATA_WIDTH-1:0]           dm_resp_data_i,
    input  logic [DMI_OP_WIDTH-1:0]             dm_resp_op_i,

    output logic [$clog2(NUM_REQ)-1:0]          grant_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("dmi_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dmi_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    dmi_arb_state_e              state_q;
    logic [IDX_W-1:0]            rr_ptr_q;
    logic [IDX_W-1:0]            grant_q;
    logic [DMI_ADDR_WIDTH-1:0]   addr_q;
    logic [DMI_DATA_WIDTH-1:0]   data_q;
    logic [DMI_OP_WIDTH-1:0]     op_q;
    logic [DMI_DATA_WIDTH-1:0]   resp_data_q;
    logic [DMI_OP_WIDTH-1:0]     resp_op_q;

    logic [NUM_REQ-1:0]          arb_gnt;
    logic [IDX_W-1:0]            arb_idx;
    logic                        arb_valid;
    logic [IDX_W-1:0]            rr_ptr_next;
    logic [NUM_REQ-1:0]          grant_onehot;

    logic [DMI_ADDR_WIDTH-1:0]   sel_addr;
    logic [DMI_DATA_WIDTH-1:0]   sel_data;
    logic [DMI_OP_WIDTH-1:0]     sel_op;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0]           wdog_q;
    logic                        drain_q;
    logic                        wdog_expired;

    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (r_req_valid_i),
        .ptr       (rr_ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign rr_ptr_next  = IDX_W'(rr_wrap(32'(arb_idx), NUM_REQ));
    assign grant_onehot = NUM_REQ'(1) << grant_q;

    // Route the winning requester's payload toward the request latches
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_op   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = r_req_addr_i[i*DMI_ADDR_WIDTH +: DMI_ADDR_WIDTH];
                sel_data = r_req_data_i[i*DMI_DATA_WIDTH +: DMI_DATA_WIDTH];
                sel_op   = r_req_op_i[i*DMI_OP_WIDTH +: DMI_OP_WIDTH];
            end
        end
    end

    // Request accept is only offered in IDLE, and never while reset is sampled
    always_comb begin
        r_req_ready_o = '0;
        if (state_q == ARB_IDLE && !rst_i) begin
            r_req_ready_o = arb_gnt;
        end
    end

    // DM responses are taken in WAIT; with the watchdog, also drained in IDLE
    always_comb begin
        dm_resp_ready_o = (state_q == ARB_WAIT);
`ifdef DMI_ARB_TIMEOUT_EN
        if (state_q == ARB_IDLE && drain_q) begin
            dm_resp_ready_o = 1'b1;
        end
`endif
    end

    assign dm_req_addr_o = addr_q;
    assign dm_req_data_o = data_q;
    assign dm_req_op_o   = op_q;
    assign r_resp_data_o = resp_data_q;
    assign r_resp_op_o   = resp_op_q;
    assign grant_o       = grant_q;

    // Transaction FSM: grant, issue to DM, wait for DM response, reply
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            op_q           <= '0;
            resp_data_q    <= '0;
            resp_op_q      <= '0;
            dm_req_valid_o <= 1'b0;
            r_resp_valid_o <= '0;
`ifdef DMI_ARB_TIMEOUT_EN
            wdog_q         <= '0;
            drain_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
`ifdef DMI_ARB_TIMEOUT_EN
                    if (drain_q && dm_resp_valid_i) begin
                        drain_q <= 1'b0;
                    end
                    wdog_q <= '0;
`endif
                    if (arb_valid) begin
                        grant_q        <= arb_idx;
                        rr_ptr_q       <= rr_ptr_next;
                        addr_q         <= sel_addr;
                        data_q         <= sel_data;
                        op_q           <= sel_op;
                        dm_req_valid_o <= 1'b1;
                        state_q        <= ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    if (dm_req_ready_i) begin
                        dm_req_valid_o <= 1'b0;
                        state_q        <= ARB_WAIT;
                    end
`ifdef DMI_ARB_TIMEOUT_EN
                    // DM never took the request: withdraw it, nothing to drain
                    else if (wdog_expired) begin
                        dm_req_valid_o <= 1'b0;
                        resp_data_q    <= '0;
                        resp_op_q      <= DMI_OP_FAILED;
                        r_resp_valid_o <= grant_onehot;
                        state_q        <= ARB_REPLY;
                    end
                    wdog_q <= wdog_q + 1'b1;
`endif
                end

                ARB_WAIT: begin
                    if (dm_resp_valid_i) begin
`ifdef DMI_ARB_TIMEOUT_EN
                        // A leftover response from a timed-out transaction
                        // is swallowed; keep waiting for our own
                        if (drain_q) begin
                            drain_q <= 1'b0;
                        end else
`endif
                        begin
                            resp_data_q    <= dm_resp_data_i;
                            resp_op_q      <= dm_resp_op_i;
                            r_resp_valid_o <= grant_onehot;
                            state_q        <= ARB_REPLY;
                        end
                    end
`ifdef DMI_ARB_TIMEOUT_EN
                    // DM accepted the request, so a late response may still come
                    else if (wdog_expired) begin
                        resp_data_q    <= '0;
                        resp_op_q      <= DMI_OP_FAILED;
                        r_resp_valid_o <= grant_onehot;
                        drain_q        <= 1'b1;
                        state_q        <= ARB_REPLY;
                    end
                    wdog_q <= wdog_q + 1'b1;
`endif
                end

                ARB_REPLY: begin
                    if (r_resp_ready_i[grant_q]) begin
                        r_resp_valid_o <= '0;
                        state_q        <= ARB_IDLE;
                    end
                end

                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
